// File: rtl/interrupt_request_gen_pkg.sv
// rtl/interrupt_request_gen_pkg.sv - shared types and vector constants for the interrupt request generator
// Purpose: FSM state encoding, vector-select encoding and the 6502-style
//          interrupt vector addresses used by interrupt_request_gen.
package interrupt_request_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    SERVICE = 2'b10
  } irq_state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    IRQ  = 2'b01,
    NMI  = 2'b10
  } vector_sel_t;

  localparam logic [15:0] NMI_VECTOR = 16'hFFFA;
  localparam logic [15:0] IRQ_VECTOR = 16'hFFFE;

  // Address the decoder fetches for a given vector selection.
  function automatic logic [15:0] vector_address(input vector_sel_t sel);
    case (sel)
      NMI:     vector_address = NMI_VECTOR;
      IRQ:     vector_address = IRQ_VECTOR;
      default: vector_address = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_pin_sync.sv
// rtl/interrupt_pin_sync.sv - multi-flop synchronizer for an active-low async pin
// Purpose: brings an asynchronous pin into the clk domain.
// Ports:
//   clk   - sampling clock, every edge (no clock enable)
//   nrst  - synchronous active-low reset; all stages reset to 1 (pin idle)
//   din   - asynchronous pin
//   dout  - synchronized pin, SYNC_STAGES cycles late
module interrupt_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stages <= '1;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = stages[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_request_gen.sv
// rtl/interrupt_request_gen.sv - NMI/IRQ request generation and interrupt-sequence sequencing
// Purpose: synchronizes nNMI/nIRQ, latches NMI falling edges, registers the
//          unmasked IRQ level and runs the IDLE/PENDING/SERVICE handshake with
//          the instruction decoder.
// Ports:
//   clk, nrst               - clock, synchronous active-low reset
//   enableFFs               - CPU clock enable; low stalls FSM, counter, IRQ register
//   nNMI, nIRQ              - asynchronous active-low interrupt pins
//   processStatusRegIFlag   - I flag, masks IRQ when 1
//   instructionBoundary     - decoder at an opcode-fetch cycle
//   interruptAcknowleged    - decoder injects the interrupt sequence now
//   nmiGenerated            - latched NMI edge awaiting acknowledge
//   irqGenerated            - registered unmasked IRQ
//   interruptPending        - asks decoder to inject the sequence
//   vectorSel               - 00 none, 01 IRQ, 10 NMI
//   serviceActive           - interrupt sequence in progress
module interrupt_request_gen
  import interrupt_request_gen_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SERVICE_CYCLES = 7
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enableFFs,
  input  logic       nNMI,
  input  logic       nIRQ,
  input  logic       processStatusRegIFlag,
  input  logic       instructionBoundary,
  input  logic       interruptAcknowleged,
  output logic       nmiGenerated,
  output logic       irqGenerated,
  output logic       interruptPending,
  output logic [1:0] vectorSel,
  output logic       serviceActive
);

  // Cycles after reset until the synchronizer and edge-history flop hold
  // real pin samples instead of their reset value of 1.
  localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic        nmi_sync;
  logic        irq_sync;
  logic        nmi_prev;
  logic [2:0]  arm_cnt;
  logic        armed;
  logic        nmi_edge;
  logic        nmi_clear;
  logic        nmi_q;
  logic        irq_q;
  logic        pending_q;
  logic        service_q;
  irq_state_t  state_q, state_n;
  vector_sel_t vsel_q, vsel_n;
  logic [2:0]  cnt_q, cnt_n;

  interrupt_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk  (clk),
    .nrst (nrst),
    .din  (nNMI),
    .dout (nmi_sync)
  );

  interrupt_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk  (clk),
    .nrst (nrst),
    .din  (nIRQ),
    .dout (irq_sync)
  );

  // Edge detection is blocked until the sync chain has flushed its reset
  // ones; otherwise a pin held low through reset release would look like a
  // fresh high-to-low transition.
  assign armed     = (arm_cnt == ARM_CYCLES);
  assign nmi_edge  = armed & nmi_prev & ~nmi_sync;
  assign nmi_clear = enableFFs & (state_q == PENDING) & interruptAcknowleged
                     & (vsel_q == NMI);

  always_comb begin
    state_n = state_q;
    vsel_n  = vsel_q;
    cnt_n   = cnt_q;
    if (enableFFs) begin
      case (state_q)
        IDLE: begin
          if (instructionBoundary && (nmi_q || irq_q)) begin
            state_n = PENDING;
            vsel_n  = nmi_q ? NMI : IRQ;
          end
        end
        PENDING: begin
          if (interruptAcknowleged) begin
            state_n = SERVICE;
            cnt_n   = 3'(SERVICE_CYCLES - 1);
          end else if (vsel_q == IRQ && nmi_q) begin
            // Upgrade only ahead of the ack so the NMI clear above always
            // matches the vector actually serviced.
            vsel_n = NMI;
          end
        end
        SERVICE: begin
          if (cnt_q == 3'd0) begin
            state_n = IDLE;
            vsel_n  = NONE;
          end else begin
            cnt_n = cnt_q - 3'd1;
          end
        end
        default: begin
          state_n = IDLE;
          vsel_n  = NONE;
          cnt_n   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      nmi_prev  <= 1'b1;
      arm_cnt   <= 3'd0;
      nmi_q     <= 1'b0;
      irq_q     <= 1'b0;
      state_q   <= IDLE;
      vsel_q    <= NONE;
      cnt_q     <= 3'd0;
      pending_q <= 1'b0;
      service_q <= 1'b0;
    end else begin
      nmi_prev <= nmi_sync;
      if (!armed) begin
        arm_cnt <= arm_cnt + 3'd1;
      end
      // A new edge wins over a coincident clearing acknowledge.
      nmi_q <= nmi_edge | (nmi_q & ~nmi_clear);
      if (enableFFs) begin
        irq_q <= ~irq_sync & ~processStatusRegIFlag;
      end
      state_q   <= state_n;
      vsel_q    <= vsel_n;
      cnt_q     <= cnt_n;
      pending_q <= (state_n == PENDING);
      service_q <= (state_n == SERVICE);
    end
  end

  assign nmiGenerated     = nmi_q;
  assign irqGenerated     = irq_q;
  assign interruptPending = pending_q;
  assign vectorSel        = vsel_q;
  assign serviceActive    = service_q;

endmodule

// File: tb/tb_interrupt_request_gen.sv
// tb/tb_interrupt_request_gen.sv - directed self-checking bench for interrupt_request_gen
module tb_interrupt_request_gen;

  logic       clk;
  logic       nrst;
  logic       enableFFs;
  logic       nNMI;
  logic       nIRQ;
  logic       processStatusRegIFlag;
  logic       instructionBoundary;
  logic       interruptAcknowleged;
  logic       nmiGenerated;
  logic       irqGenerated;
  logic       interruptPending;
  logic [1:0] vectorSel;
  logic       serviceActive;

  int vectors;
  int miscompares;

  interrupt_request_gen #(.SYNC_STAGES(2), .SERVICE_CYCLES(7)) dut (
    .clk                   (clk),
    .nrst                  (nrst),
    .enableFFs             (enableFFs),
    .nNMI                  (nNMI),
    .nIRQ                  (nIRQ),
    .processStatusRegIFlag (processStatusRegIFlag),
    .instructionBoundary   (instructionBoundary),
    .interruptAcknowleged  (interruptAcknowleged),
    .nmiGenerated          (nmiGenerated),
    .irqGenerated          (irqGenerated),
    .interruptPending      (interruptPending),
    .vectorSel             (vectorSel),
    .serviceActive         (serviceActive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    expect_eq({tag, ".nmi"},  int'(nmiGenerated),     0);
    expect_eq({tag, ".irq"},  int'(irqGenerated),     0);
    expect_eq({tag, ".pend"}, int'(interruptPending), 0);
    expect_eq({tag, ".vsel"}, int'(vectorSel),        0);
    expect_eq({tag, ".svc"},  int'(serviceActive),    0);
  endtask

  // Counts edges until serviceActive drops (bounded); service just started.
  task automatic count_service(input string tag, input int exp);
    int n;
    n = 1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (!serviceActive) break;
      n++;
    end
    expect_eq(tag, n, exp);
  endtask

  initial begin
    int saw_pend;
    int saw_irq;
    vectors               = 0;
    miscompares           = 0;
    nrst                  = 1'b0;
    enableFFs             = 1'b1;
    nNMI                  = 1'b1;
    nIRQ                  = 1'b1;
    processStatusRegIFlag = 1'b1;
    instructionBoundary   = 1'b0;
    interruptAcknowleged  = 1'b0;
    step(2);
    check_all_zero("reset");
    nrst = 1'b1;
    step(5);

    // NMI edge latency and injection
    nNMI = 1'b0;
    step(2);
    expect_eq("nmi_lat_early", int'(nmiGenerated), 0);
    step(1);
    expect_eq("nmi_lat", int'(nmiGenerated), 1);
    step(2);
    instructionBoundary = 1'b1;
    step(1);
    instructionBoundary = 1'b0;
    expect_eq("nmi_pend", int'(interruptPending), 1);
    expect_eq("nmi_vsel", int'(vectorSel), 2);
    interruptAcknowleged = 1'b1;
    step(1);
    interruptAcknowleged = 1'b0;
    expect_eq("nmi_svc", int'(serviceActive), 1);
    expect_eq("nmi_pend_drop", int'(interruptPending), 0);
    expect_eq("nmi_cleared", int'(nmiGenerated), 0);
    count_service("nmi_svc_len", 7);
    expect_eq("nmi_vsel_none", int'(vectorSel), 0);
    expect_eq("nmi_held_once", int'(nmiGenerated), 0);
    nNMI = 1'b1;

    // IRQ masked by I flag
    nIRQ = 1'b0;
    instructionBoundary = 1'b1;
    saw_pend = 0;
    saw_irq = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (interruptPending) saw_pend = 1;
      if (irqGenerated) saw_irq = 1;
    end
    expect_eq("irq_masked", saw_irq, 0);
    expect_eq("irq_masked_pend", saw_pend, 0);
    processStatusRegIFlag = 1'b0;
    step(1);
    expect_eq("irq_unmasked", int'(irqGenerated), 1);
    step(1);
    expect_eq("irq_pend", int'(interruptPending), 1);
    expect_eq("irq_vsel", int'(vectorSel), 1);
    instructionBoundary = 1'b0;
    nIRQ = 1'b1;
    processStatusRegIFlag = 1'b1;

    // NMI hijacks a committed IRQ
    nNMI = 1'b0;
    step(3);
    expect_eq("hijack_nmi", int'(nmiGenerated), 1);
    expect_eq("irq_committed", int'(interruptPending), 1);
    step(1);
    expect_eq("hijack_vsel", int'(vectorSel), 2);
    interruptAcknowleged = 1'b1;
    step(1);
    interruptAcknowleged = 1'b0;
    expect_eq("hijack_svc", int'(serviceActive), 1);
    expect_eq("hijack_nmi_clr", int'(nmiGenerated), 0);
    count_service("hijack_svc_len", 7);
    nNMI = 1'b1;
    step(4);

    // Stall: edge still latched, FSM frozen
    enableFFs = 1'b0;
    nNMI = 1'b0;
    step(3);
    expect_eq("stall_nmi", int'(nmiGenerated), 1);
    instructionBoundary = 1'b1;
    step(2);
    expect_eq("stall_frozen", int'(interruptPending), 0);
    enableFFs = 1'b1;
    step(1);
    instructionBoundary = 1'b0;
    expect_eq("stall_resume", int'(interruptPending), 1);
    expect_eq("stall_vsel", int'(vectorSel), 2);
    interruptAcknowleged = 1'b1;
    step(1);
    interruptAcknowleged = 1'b0;
    enableFFs = 1'b0;
    step(5);
    expect_eq("stall_svc_hold", int'(serviceActive), 1);
    enableFFs = 1'b1;
    count_service("stall_svc_len", 7);

    // nNMI low across reset release, then reset mid-SERVICE
    nrst = 1'b0;
    step(2);
    nrst = 1'b1;
    step(6);
    expect_eq("rst_low_nmi", int'(nmiGenerated), 0);
    nNMI = 1'b1;
    step(4);
    nNMI = 1'b0;
    step(3);
    expect_eq("rst_setup_nmi", int'(nmiGenerated), 1);
    instructionBoundary = 1'b1;
    step(1);
    instructionBoundary = 1'b0;
    interruptAcknowleged = 1'b1;
    step(1);
    interruptAcknowleged = 1'b0;
    step(2);
    expect_eq("rst_setup_svc", int'(serviceActive), 1);
    nrst = 1'b0;
    step(1);
    check_all_zero("rst_mid_svc");
    nrst = 1'b1;
    step(6);
    expect_eq("rst_no_residual_pend", int'(interruptPending), 0);
    expect_eq("rst_no_residual_nmi", int'(nmiGenerated), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
